fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction fetch queue that decouples the IF stage from ID. It drives the instruction bus sequentially from an internal fetch PC and buffers up to DEPTH fetched {pc, instr} entries. Decode pops entries through a valid/ready handshake, and a redirect port (branch, CSR or exception flush) discards queued and in-flight fetches. It replaces the stall-coupled IF path between the PC register and the IF/ID register.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 64'h0000_0000_8000_0000: fetch PC after reset.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ireq  out  ibus_req_t  instruction bus request (valid, addr).
- iresp  in  ibus_resp_t  instruction bus response (data_ok, data[31:0]).
- redirect_valid  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  64  new fetch PC.
- out_valid  out  1  head entry present.
- out_ready  in  1  decode consumes the head this cycle.
- out_pc  out  64  head PC.
- out_instr  out  32  head instruction.
- out_misalign  out  1  head is an instruction-address-misaligned marker; out_instr is 0.
- count  out  $clog2(DEPTH)+1  occupancy, for debug and perf counters.

## Operation
- FSM states: FETCH, DISCARD.
  - FETCH: ireq.valid=1 with ireq.addr=fetch_pc when no request is outstanding and count<DEPTH; otherwise 0.
  - DISCARD: ireq.valid=1 on the stale address, waiting only for data_ok.
- Bus rule: once ireq.valid rises, valid and addr stay constant until the cycle data_ok=1. Requests are never withdrawn. At most one request is outstanding.
- Slot reservation: a request is issued only when count<DEPTH. Count never increases while a request is in flight, so the response always has a free slot.
- On data_ok in FETCH without redirect:
  - push {fetch_pc, iresp.data, 0};
  - fetch_pc += 4 (64-bit wrap).
- Misaligned fetch: fetch_pc[1:0]≠0 in FETCH with count<DEPTH.
  - Push {fetch_pc, 0, 1} without any bus request.
  - Then stall. No further pushes occur until a redirect.
- Pop: when out_valid && out_ready, the head advances.
- Push and pop in the same cycle: count is unchanged and both take effect.
- Pop on an empty queue is ignored.
- Redirect (highest priority):
  - next cycle count=0 and fetch_pc=redirect_pc;
  - any push or pop in that cycle is dropped.
  - If a request is outstanding and data_ok=0 this cycle, go to DISCARD.
  - If data_ok=1 this cycle, drop the data and stay in FETCH.
- DISCARD: on data_ok, drop the data and return to FETCH. A new request issues the following cycle.
- A second redirect during DISCARD updates fetch_pc only.
- Empty queue: out_pc, out_instr and out_misalign read 0.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full means count==DEPTH.

## Timing
- Reset (async assert): state FETCH, count 0, pointers 0, fetch_pc RESET_PC. All outputs 0, including ireq.valid.
  - First request goes out the first cycle after reset deasserts.
  - Reset mid-transaction abandons the outstanding request. The bus is reset with the core.
- Fetch latency: request issued at cycle t, data_ok at t+k (k≥0) → entry written at the t+k edge, out_valid=1 at t+k+1. There is no combinational bypass from iresp to out_*.
- Redirect at cycle t with nothing outstanding → ireq.valid=1, addr=redirect_pc at t+1.
- out_* are registered-state outputs. out_ready does not feed back into ireq combinationally.
- Full queue: ireq.valid stays 0 until a pop. It resumes the cycle after the pop edge.

## Structure
- In package pipes:
  - fq_entry_t {u64 pc; u32 instr; u1 misalign};
  - fq_state_e {FQ_FETCH, FQ_DISCARD}.
- Sub-module fetch_queue_ram: a DEPTH×fq_entry_t register array with write port (we, waddr, wdata) and async read port (raddr). It is reset-free; validity is tracked by count.
- The top holds the FSM, fetch_pc, pointers and count.

## Test plan
- Zero-wait bus, out_ready=1 after reset: ireq.addr steps 0x80000000, 0x80000004, …; first out_valid 2 cycles after reset release; out_pc tracks in order.
- out_ready=0, DEPTH=4: exactly 4 requests complete, then ireq.valid=0 and count=4; one pop → ireq.valid=1 the next cycle at 0x80000010.
- 3-cycle bus latency, redirect to 0x80001000 on the 2nd wait cycle: ireq.addr is held at the stale value until data_ok; that data is dropped; next request is 0x80001000; count=0 until its response.
- Redirect in the same cycle as data_ok and out_ready: no push, no pop, count=0, next ireq.addr=redirect_pc.
- Redirect to 0x80000002: no bus request; one entry with out_misalign=1, out_pc=0x80000002, out_instr=0; the queue then stalls until redirect to 0x80000100.
- Async reset asserted mid-request with count=3: all outputs 0 immediately; after release fetch restarts at RESET_PC with count=0.

Source files
------------

// File: rtl/pipes.sv
// Shared fetch-path types: instruction bus payloads and fetch-queue entries.
package pipes;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic            data_ok;
        logic [ILEN-1:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            misalign;
    } fq_entry_t;

    typedef enum logic {
        FQ_FETCH   = 1'b0,
        FQ_DISCARD = 1'b1
    } fq_state_e;

endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage for the fetch queue: one synchronous write port, one async read port.
// No reset; the owner tracks which slots hold live data.
module fetch_queue_ram
    import pipes::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  fq_entry_t                  wdata_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr_i,
    output fq_entry_t                  rdata_o
);

    fq_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: sequential bus fetch from an internal PC into a small
// FIFO of {pc, instr, misalign}, popped by decode and flushed by redirects.
module fetch_queue
    import pipes::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic                      clk,
    input  logic                      reset,
    output ibus_req_t                 ireq,
    input  ibus_resp_t                iresp,
    input  logic                      redirect_valid,
    input  logic [63:0]               redirect_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [63:0]               out_pc,
    output logic [31:0]               out_instr,
    output logic                      out_misalign,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fq_state_e        state_q, state_d;
    logic [63:0]      fetch_pc_q, fetch_pc_d;
    logic [63:0]      discard_addr_q, discard_addr_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             stall_q, stall_d;

    logic      req_valid;
    logic      resp_fire;
    logic      fetch_push;
    logic      misalign_push;
    logic      push;
    logic      pop;
    logic      we;
    fq_entry_t wdata;
    fq_entry_t head;

    // Bus request is a function of registered state only, held off during reset.
    always_comb begin
        req_valid = 1'b0;
        if (!reset) begin
            if (state_q == FQ_DISCARD) begin
                req_valid = 1'b1;
            end else begin
                req_valid = !stall_q && (fetch_pc_q[1:0] == 2'b00) && (count_q != FULL_CNT);
            end
        end
    end

    assign resp_fire     = req_valid && iresp.data_ok;
    assign fetch_push    = (state_q == FQ_FETCH) && resp_fire;
    assign misalign_push = (state_q == FQ_FETCH) && !stall_q && (fetch_pc_q[1:0] != 2'b00)
                           && (count_q != FULL_CNT);
    assign push          = fetch_push || misalign_push;
    assign pop           = (count_q != '0) && out_ready;

    always_comb begin
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        discard_addr_d = discard_addr_q;
        wptr_d         = wptr_q;
        rptr_d         = rptr_q;
        count_d        = count_q;
        stall_d        = stall_q;
        we             = 1'b0;
        wdata.pc       = fetch_pc_q;
        wdata.instr    = iresp.data;
        wdata.misalign = 1'b0;

        if (redirect_valid) begin
            // Flush wins over everything; a still-pending request must be drained first.
            fetch_pc_d = redirect_pc;
            count_d    = '0;
            wptr_d     = '0;
            rptr_d     = '0;
            stall_d    = 1'b0;
            if (req_valid && !iresp.data_ok) begin
                state_d = FQ_DISCARD;
                if (state_q == FQ_FETCH) begin
                    discard_addr_d = fetch_pc_q;
                end
            end else begin
                state_d = FQ_FETCH;
            end
        end else if (state_q == FQ_DISCARD) begin
            if (resp_fire) begin
                state_d = FQ_FETCH;
            end
        end else begin
            if (misalign_push) begin
                wdata.instr    = '0;
                wdata.misalign = 1'b1;
                stall_d        = 1'b1;
            end
            if (fetch_push) begin
                fetch_pc_d = fetch_pc_q + 64'd4;
            end
            we = push;
            if (push) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= FQ_FETCH;
            fetch_pc_q     <= RESET_PC;
            discard_addr_q <= '0;
            wptr_q         <= '0;
            rptr_q         <= '0;
            count_q        <= '0;
            stall_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            fetch_pc_q     <= fetch_pc_d;
            discard_addr_q <= discard_addr_d;
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            count_q        <= count_d;
            stall_q        <= stall_d;
        end
    end

    fetch_queue_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (wptr_q),
        .wdata_i (wdata),
        .raddr_i (rptr_q),
        .rdata_o (head)
    );

    always_comb begin
        ireq.valid = req_valid;
        ireq.addr  = '0;
        if (req_valid) begin
            ireq.addr = (state_q == FQ_DISCARD) ? discard_addr_q : fetch_pc_q;
        end
    end

    assign out_valid    = (count_q != '0);
    assign out_pc       = out_valid ? head.pc       : '0;
    assign out_instr    = out_valid ? head.instr    : '0;
    assign out_misalign = out_valid ? head.misalign : 1'b0;
    assign count        = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: bus responder with programmable latency,
// scoreboard of expected queue entries, and directed scenario tasks.
module tb_fetch_queue;
    import pipes::*;

    localparam int unsigned DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_misalign;
    logic [$clog2(DEPTH):0] count;

    int          lat = 0;
    int          wait_cnt;
    int          n_total = 0;
    int          n_pass = 0;
    fq_entry_t   sb[$];
    logic [63:0] model_pc = RESET_PC;
    bit          drop_pending = 1'b0;
    bit          prev_hold = 1'b0;
    logic [63:0] prev_addr = '0;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq           (ireq),
        .iresp          (iresp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_misalign   (out_misalign),
        .count          (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9bdf;
    endfunction

    // Bus responder: data_ok once the request has waited 'lat' cycles.
    always @(posedge clk or posedge reset) begin
        if (reset) wait_cnt <= 0;
        else if (ireq.valid && !iresp.data_ok) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    always_comb begin
        iresp.data_ok = ireq.valid && (wait_cnt >= lat);
        iresp.data    = ireq.valid ? mem_word(ireq.addr) : 32'h0;
    end

    // Scoreboard monitor: expected entries pushed on accepted responses, popped on decode handshakes.
    always @(negedge clk) begin
        fq_entry_t e;
        if (reset) begin
            sb.delete();
            model_pc     = RESET_PC;
            drop_pending = 1'b0;
            prev_hold    = 1'b0;
        end else begin
            if (prev_hold) begin
                n_total++;
                if (ireq.valid !== 1'b1 || ireq.addr !== prev_addr)
                    $display("FAIL bus_hold: got valid=%b addr=%h expected valid=1 addr=%h",
                             ireq.valid, ireq.addr, prev_addr);
                else n_pass++;
            end
            prev_hold = ireq.valid && !iresp.data_ok;
            prev_addr = ireq.addr;
            if (redirect_valid) begin
                sb.delete();
                model_pc     = redirect_pc;
                drop_pending = ireq.valid && !iresp.data_ok;
                if (redirect_pc[1:0] != 2'b00) begin
                    e.pc = redirect_pc; e.instr = 32'h0; e.misalign = 1'b1;
                    sb.push_back(e);
                end
            end else begin
                if (out_valid && out_ready) begin
                    n_total++;
                    if (sb.size() == 0) begin
                        $display("FAIL sb_pop: got entry pc=%h expected empty queue", out_pc);
                    end else begin
                        e = sb.pop_front();
                        if (out_pc !== e.pc || out_instr !== e.instr || out_misalign !== e.misalign)
                            $display("FAIL sb_pop: got pc=%h instr=%h mis=%b expected pc=%h instr=%h mis=%b",
                                     out_pc, out_instr, out_misalign, e.pc, e.instr, e.misalign);
                        else n_pass++;
                    end
                end
                if (ireq.valid && iresp.data_ok) begin
                    if (drop_pending) begin
                        drop_pending = 1'b0;
                    end else begin
                        n_total++;
                        if (ireq.addr !== model_pc)
                            $display("FAIL fetch_addr: got %h expected %h", ireq.addr, model_pc);
                        else n_pass++;
                        e.pc = model_pc; e.instr = mem_word(model_pc); e.misalign = 1'b0;
                        sb.push_back(e);
                        model_pc = model_pc + 64'd4;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        lat = 0; out_ready = 1'b1; reset = 1'b1;
        step(); step();
        n_total++; if (ireq.valid !== 1'b0) $display("FAIL rst_req_valid: got %b expected 0", ireq.valid); else n_pass++;
        n_total++; if (ireq.addr !== 64'h0) $display("FAIL rst_req_addr: got %h expected 0", ireq.addr); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_total++; if (count !== 3'd0) $display("FAIL rst_count: got %0d expected 0", count); else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        n_total++; if (ireq.valid !== 1'b1 || ireq.addr !== RESET_PC)
            $display("FAIL first_req: got valid=%b addr=%h expected 1 %h", ireq.valid, ireq.addr, RESET_PC); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL first_out_early: got %b expected 0", out_valid); else n_pass++;
        @(negedge clk);
        n_total++; if (out_valid !== 1'b1 || out_pc !== RESET_PC)
            $display("FAIL first_out: got valid=%b pc=%h expected 1 %h", out_valid, out_pc, RESET_PC); else n_pass++;
        n_total++; if (ireq.addr !== RESET_PC + 64'd4)
            $display("FAIL second_req: got %h expected %h", ireq.addr, RESET_PC + 64'd4); else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_total++; if (count !== 3'd1 || ireq.valid !== 1'b1)
                $display("FAIL b2b_steady: got count=%0d valid=%b expected 1 1", count, ireq.valid); else n_pass++;
        end
    endtask

    task automatic test_full();
        lat = 0; out_ready = 1'b0;
        pulse_reset();
        repeat (8) @(negedge clk);
        n_total++; if (count !== 3'd4) $display("FAIL full_count: got %0d expected 4", count); else n_pass++;
        n_total++; if (ireq.valid !== 1'b0) $display("FAIL full_req: got %b expected 0", ireq.valid); else n_pass++;
        @(posedge clk); #1; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        @(negedge clk);
        n_total++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_0010)
            $display("FAIL full_resume: got valid=%b addr=%h expected 1 80000010", ireq.valid, ireq.addr); else n_pass++;
        n_total++; if (count !== 3'd3) $display("FAIL full_after_pop: got %0d expected 3", count); else n_pass++;
        out_ready = 1'b1;
        repeat (6) step();
    endtask

    task automatic test_redirect_discard();
        lat = 3; out_ready = 1'b1;
        pulse_reset();
        step();
        redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
        step();
        redirect_valid = 1'b0;
        for (int c = 3; c <= 9; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                n_total++; if (ireq.valid !== 1'b1 || ireq.addr !== RESET_PC)
                    $display("FAIL discard_hold c%0d: got valid=%b addr=%h expected 1 %h", c, ireq.valid, ireq.addr, RESET_PC); else n_pass++;
            end
            if (c == 5) begin
                n_total++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_1000)
                    $display("FAIL discard_next: got valid=%b addr=%h expected 1 80001000", ireq.valid, ireq.addr); else n_pass++;
            end
            if (c <= 8) begin
                n_total++; if (count !== 3'd0) $display("FAIL discard_count c%0d: got %0d expected 0", c, count); else n_pass++;
            end else begin
                n_total++; if (count !== 3'd1 || out_pc !== 64'h8000_1000)
                    $display("FAIL discard_first: got count=%0d pc=%h expected 1 80001000", count, out_pc); else n_pass++;
            end
        end
    endtask

    task automatic test_redirect_same_cycle();
        lat = 0; out_ready = 1'b1;
        repeat (4) step();
        redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
        @(negedge clk);
        n_total++; if (!(ireq.valid && iresp.data_ok && out_valid))
            $display("FAIL same_pre: got valid=%b ok=%b out=%b expected 1 1 1", ireq.valid, iresp.data_ok, out_valid); else n_pass++;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_total++; if (count !== 3'd0 || out_valid !== 1'b0)
            $display("FAIL same_count: got count=%0d out_valid=%b expected 0 0", count, out_valid); else n_pass++;
        n_total++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_2000)
            $display("FAIL same_next: got valid=%b addr=%h expected 1 80002000", ireq.valid, ireq.addr); else n_pass++;
    endtask

    task automatic test_misalign();
        lat = 0;
        step();
        out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0002;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_total++; if (ireq.valid !== 1'b0 || count !== 3'd0)
            $display("FAIL mis_noreq: got valid=%b count=%0d expected 0 0", ireq.valid, count); else n_pass++;
        @(negedge clk);
        n_total++; if (out_valid !== 1'b1 || out_misalign !== 1'b1 || out_pc !== 64'h8000_0002 || out_instr !== 32'h0)
            $display("FAIL mis_entry: got v=%b mis=%b pc=%h instr=%h expected 1 1 80000002 0",
                     out_valid, out_misalign, out_pc, out_instr); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_total++; if (count !== 3'd1 || ireq.valid !== 1'b0)
                $display("FAIL mis_stall: got count=%0d valid=%b expected 1 0", count, ireq.valid); else n_pass++;
        end
        step();
        out_ready = 1'b1;
        repeat (4) step();
        @(negedge clk);
        n_total++; if (count !== 3'd0 || ireq.valid !== 1'b0)
            $display("FAIL mis_drained: got count=%0d valid=%b expected 0 0", count, ireq.valid); else n_pass++;
        step();
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_total++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_0100)
            $display("FAIL mis_recover: got valid=%b addr=%h expected 1 80000100", ireq.valid, ireq.addr); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step();
            out_ready      = 1'($urandom_range(0, 1));
            lat            = int'($urandom_range(0, 3));
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = 64'h8000_0000 + 64'($urandom_range(0, 255)) * 64'd4;
            @(negedge clk);
            n_total++; if (count > 3'(DEPTH)) $display("FAIL rand_count: got %0d expected <= %0d", count, DEPTH); else n_pass++;
        end
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit found;
        lat = 3; out_ready = 1'b0; found = 1'b0;
        pulse_reset();
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (count == 3'd3) found = 1'b1;
        end
        n_total++; if (!found || ireq.valid !== 1'b1)
            $display("FAIL midrst_setup: got count=%0d valid=%b expected 3 1", count, ireq.valid); else n_pass++;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        n_total++; if (ireq.valid !== 1'b0 || ireq.addr !== 64'h0)
            $display("FAIL midrst_req: got valid=%b addr=%h expected 0 0", ireq.valid, ireq.addr); else n_pass++;
        n_total++; if (out_valid !== 1'b0 || count !== 3'd0 || out_pc !== 64'h0 || out_instr !== 32'h0 || out_misalign !== 1'b0)
            $display("FAIL midrst_out: got v=%b cnt=%0d pc=%h instr=%h mis=%b expected all 0",
                     out_valid, count, out_pc, out_instr, out_misalign); else n_pass++;
        step();
        reset = 1'b0;
        @(negedge clk);
        n_total++; if (ireq.valid !== 1'b1 || ireq.addr !== RESET_PC || count !== 3'd0)
            $display("FAIL midrst_restart: got valid=%b addr=%h count=%0d expected 1 %h 0",
                     ireq.valid, ireq.addr, count, RESET_PC); else n_pass++;
    endtask

    task automatic test_drain();
        lat = 0; out_ready = 1'b1;
        step();
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0006;
        step();
        redirect_valid = 1'b0;
        repeat (8) step();
        @(negedge clk);
        n_total++; if (sb.size() != 0) $display("FAIL drain_sb: got %0d pending expected 0", sb.size()); else n_pass++;
        n_total++; if (count !== 3'd0 || out_valid !== 1'b0 || ireq.valid !== 1'b0)
            $display("FAIL drain_idle: got count=%0d out=%b req=%b expected 0 0 0", count, out_valid, ireq.valid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_full();
        test_redirect_discard();
        test_redirect_same_cycle();
        test_misalign();
        test_random();
        test_reset_mid();
        test_drain();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
